rf_multiport: RTL and testbench

RF_MULTIPORT -- requirements
Module: rf_multiport

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_clr_ctrl.sv | 69 ++++++
 rtl/rf_multiport.sv | 118 +++++++++++
 tb/tb_rf_multiport.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the multiport register file.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_N_RD   = 2;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_clr_ctrl.sv
// Soft-clear sequencer: walks an index over every entry, one per cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RF_IDLE  | normal operation; clr_req_i starts a sweep at index 0
// RF_CLEAR | entry idx_q is zeroed this cycle; leaves after the last entry
module rf_clr_ctrl
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              clr_req_i,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_idx_o,
  output logic              clr_busy_o,
  output logic              clr_done_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_state_e         state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q;
  logic              done_q;

  // Sweep FSM with registered busy/done; a request during a sweep is ignored.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RF_IDLE: begin
          done_q <= 1'b0;
          if (clr_req_i) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RF_CLEAR: begin
          if (idx_q == LAST_IDX) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= RF_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_en_o   = busy_q;
  assign clr_idx_o  = idx_q;
  assign clr_busy_o = busy_q;
  assign clr_done_o = done_q;

endmodule

// File: rtl/rf_multiport.sv
// Register file: N_RD combinational read ports, two write ports (port 1
// wins on collision), per-entry reservation bits and a soft clear sweep.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_RD     = RF_N_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst_n,
  input  logic [N_RD*ADDR_W-1:0]   raddr,
  output logic [N_RD*DATA_W-1:0]   rdata,
  output logic [N_RD-1:0]          rbusy,
  input  logic [1:0]               we,
  input  logic [2*ADDR_W-1:0]      waddr,
  input  logic [2*DATA_W-1:0]      wdata,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;

  logic [ADDR_W-1:0] wa [2];
  logic [DATA_W-1:0] wd [2];
  logic [1:0]        wr_ok;
  logic              rsv_ok;

  rf_clr_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clr_ctrl (
    .cpu_clk    (cpu_clk),
    .cpu_rst_n  (cpu_rst_n),
    .clr_req_i  (clr_req),
    .clr_en_o   (clr_en),
    .clr_idx_o  (clr_idx),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done)
  );

  // Qualified write/reserve strobes: blocked during a sweep and at the zero register.
  always_comb begin
    wr_ok  = '0;
    rsv_ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wa[k]    = waddr[k*ADDR_W +: ADDR_W];
      wd[k]    = wdata[k*DATA_W +: DATA_W];
      wr_ok[k] = we[k] && !clr_en && !((ZERO_REG != 0) && (wa[k] == '0));
    end
    rsv_ok = rsv_en && !clr_en && !((ZERO_REG != 0) && (rsv_addr == '0));
  end

  // Array and busy update; port 1 is applied after port 0 and a reservation last, so both win.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else if (clr_en) begin
      mem_q[clr_idx]  <= '0;
      busy_q[clr_idx] <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_ok[k]) begin
          mem_q[wa[k]]  <= wd[k];
          busy_q[wa[k]] <= 1'b0;
        end
      end
      if (rsv_ok) begin
        busy_q[rsv_addr] <= 1'b1;
      end
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_v;
    logic              rb_v;
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd_v  = '0;
    rb_v  = 1'b0;
    for (int i = 0; i < N_RD; i++) begin
      ra   = raddr[i*ADDR_W +: ADDR_W];
      rd_v = mem_q[ra];
      rb_v = busy_q[ra];
      if (BYPASS != 0) begin
        for (int k = 0; k < 2; k++) begin
          if (wr_ok[k] && (wa[k] == ra)) begin
            rd_v = wd[k];
            rb_v = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_v = '0;
        rb_v = 1'b0;
      end
      rdata[i*DATA_W +: DATA_W] = rd_v;
      rbusy[i]                  = rb_v;
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: instance A uses defaults (2 read ports, bypass),
// instance B uses 4 read ports without bypass.
module tb_rf_multiport;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2*AW-1:0] a_raddr;
  logic [2*DW-1:0] a_rdata;
  logic [1:0]      a_rbusy;
  logic [1:0]      a_we;
  logic [2*AW-1:0] a_waddr;
  logic [2*DW-1:0] a_wdata;
  logic            a_rsv_en;
  logic [AW-1:0]   a_rsv_addr;
  logic            a_clr_req, a_clr_busy, a_clr_done;

  logic [4*AW-1:0] b_raddr;
  logic [4*DW-1:0] b_rdata;
  logic [3:0]      b_rbusy;
  logic [1:0]      b_we;
  logic [2*AW-1:0] b_waddr;
  logic [2*DW-1:0] b_wdata;
  logic            b_rsv_en;
  logic [AW-1:0]   b_rsv_addr;
  logic            b_clr_req, b_clr_busy, b_clr_done;

  rf_multiport u_dut_a (
    .cpu_clk(clk), .cpu_rst_n(rst_n),
    .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
    .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
    .clr_req(a_clr_req), .clr_busy(a_clr_busy), .clr_done(a_clr_done)
  );

  rf_multiport #(.N_RD(4), .BYPASS(0)) u_dut_b (
    .cpu_clk(clk), .cpu_rst_n(rst_n),
    .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
    .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .clr_req(b_clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
  );

  typedef struct packed {
    logic [1:0]   we;
    logic [4:0]   wa0;
    logic [31:0]  wd0;
    logic [4:0]   wa1;
    logic [31:0]  wd1;
    logic         rsv;
    logic [4:0]   rsa;
    logic [19:0]  ra;   // {p3,p2,p1,p0}
    logic [127:0] rd;   // {p3,p2,p1,p0}
    logic [3:0]   rb;
  } vec_t;

  vec_t tbl_a [16];
  vec_t tbl_b [9];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain array contents and busy flags per instance.
  logic [31:0] m_mem  [2][DEPTH];
  logic        m_busy [2][DEPTH];
  logic [1:0]  s_we;
  logic [4:0]  s_wa0, s_wa1, s_rsa;
  logic [31:0] s_wd0, s_wd1;
  logic        s_rsv;

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic rsv, logic [4:0] rsa,
                              logic [19:0] ra, logic [127:0] rd, logic [3:0] rb);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.rsv = rsv; v.rsa = rsa; v.ra = ra; v.rd = rd; v.rb = rb;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_wr(input int d, input logic [1:0] we, input logic [4:0] wa0,
                          input logic [31:0] wd0, input logic [4:0] wa1, input logic [31:0] wd1,
                          input logic rsv, input logic [4:0] rsa);
    s_we = we; s_wa0 = wa0; s_wd0 = wd0; s_wa1 = wa1; s_wd1 = wd1; s_rsv = rsv; s_rsa = rsa;
    if (d == 0) begin
      a_we = we; a_waddr = {wa1, wa0}; a_wdata = {wd1, wd0}; a_rsv_en = rsv; a_rsv_addr = rsa;
    end else begin
      b_we = we; b_waddr = {wa1, wa0}; b_wdata = {wd1, wd0}; b_rsv_en = rsv; b_rsv_addr = rsa;
    end
  endtask

  task automatic idle_inputs();
    drive_wr(0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    drive_wr(1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    a_clr_req = 1'b0;
    b_clr_req = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(int d, logic [4:0] a, int byp);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = m_mem[d][a];
    if (byp != 0) begin
      if (s_we[0] && s_wa0 == a) v = s_wd0;
      if (s_we[1] && s_wa1 == a) v = s_wd1;
    end
    return v;
  endfunction

  function automatic logic exp_rb(int d, logic [4:0] a, int byp);
    if (byp != 0 && ((s_we[0] && s_wa0 == a) || (s_we[1] && s_wa1 == a))) return 1'b0;
    return m_busy[d][a];
  endfunction

  task automatic model_commit(input int d);
    if (s_we[0] && s_wa0 != 5'd0) begin m_mem[d][s_wa0] = s_wd0; m_busy[d][s_wa0] = 1'b0; end
    if (s_we[1] && s_wa1 != 5'd0) begin m_mem[d][s_wa1] = s_wd1; m_busy[d][s_wa1] = 1'b0; end
    if (s_rsv && s_rsa != 5'd0) m_busy[d][s_rsa] = 1'b1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[d][i]  = 32'd0;
        m_busy[d][i] = 1'b0;
      end
  endtask

  task automatic apply_vec(input int d, input vec_t v, input int idx);
    drive_wr(d, v.we, v.wa0, v.wd0, v.wa1, v.wd1, v.rsv, v.rsa);
    if (d == 0) a_raddr = v.ra[9:0];
    else        b_raddr = v.ra;
    @(negedge clk);
    for (int p = 0; p < ((d == 0) ? 2 : 4); p++) begin
      if (d == 0) begin
        check($sformatf("vecA%0d rdata%0d", idx, p), a_rdata[p*32 +: 32], v.rd[p*32 +: 32]);
        check($sformatf("vecA%0d rbusy%0d", idx, p), 32'(a_rbusy[p]), 32'(v.rb[p]));
      end else begin
        check($sformatf("vecB%0d rdata%0d", idx, p), b_rdata[p*32 +: 32], v.rd[p*32 +: 32]);
        check($sformatf("vecB%0d rbusy%0d", idx, p), 32'(b_rbusy[p]), 32'(v.rb[p]));
      end
    end
    @(posedge clk); #1;
  endtask

  // Counts a sweep on instance A from its first CLEAR cycle; optional probe in cycle 20.
  task automatic count_clear(input int probe, output int bc, output int dc);
    int idle_cnt;
    bc = 0; dc = 0; idle_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (a_clr_busy) bc++;
      else if (bc > 0) idle_cnt++;
      if (a_clr_done) begin
        dc++;
        check("clr_done_first_idle", idle_cnt, 1);
      end
      if (probe != 0 && bc == 20 && a_clr_busy) begin
        drive_wr(0, 2'b01, 5'd5, 32'h55, 5'd0, 32'd0, 1'b1, 5'd5);
        a_clr_req = 1'b1;
        a_raddr = {5'd31, 5'd2};
        @(negedge clk);
        check("clear_partial_cleared", a_rdata[31:0], 32'd0);
        check("clear_partial_kept", a_rdata[63:32], 32'hA500001F);
        @(posedge clk); #1;
        idle_inputs();
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bc, dc;
    model_reset();
    idle_inputs();
    a_raddr = '0;
    b_raddr = '0;

    tbl_a[0]  = mk(2'b01, 5'd5, DB, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd5, 5'd5}, {64'd0, DB, DB}, 4'b0000);
    tbl_a[1]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd5, 5'd0}, {64'd0, DB, 32'd0}, 4'b0000);
    tbl_a[2]  = mk(2'b01, 5'd0, 32'd1, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd0, 5'd0}, 128'd0, 4'b0000);
    tbl_a[3]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd5, 5'd0}, {64'd0, DB, 32'd0}, 4'b0000);
    tbl_a[4]  = mk(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, {10'd0, 5'd5, 5'd7}, {64'd0, DB, 32'h22}, 4'b0000);
    tbl_a[5]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd7, 5'd7}, {64'd0, 32'h22, 32'h22}, 4'b0000);
    tbl_a[6]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, {10'd0, 5'd3, 5'd3}, 128'd0, 4'b0000);
    tbl_a[7]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd3, 5'd3}, 128'd0, 4'b0011);
    tbl_a[8]  = mk(2'b01, 5'd3, 32'h5, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd7, 5'd3}, {64'd0, 32'h22, 32'h5}, 4'b0000);
    tbl_a[9]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd7, 5'd3}, {64'd0, 32'h22, 32'h5}, 4'b0000);
    tbl_a[10] = mk(2'b01, 5'd3, 32'h9, 5'd0, 32'd0, 1'b1, 5'd3, {10'd0, 5'd3, 5'd3}, {64'd0, 32'h9, 32'h9}, 4'b0000);
    tbl_a[11] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd3, 5'd3}, {64'd0, 32'h9, 32'h9}, 4'b0011);
    tbl_a[12] = mk(2'b10, 5'd0, 32'd0, 5'd3, 32'hA, 1'b1, 5'd0, {10'd0, 5'd0, 5'd3}, {64'd0, 32'd0, 32'hA}, 4'b0000);
    tbl_a[13] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd0, 5'd3}, {64'd0, 32'd0, 32'hA}, 4'b0000);
    tbl_a[14] = mk(2'b01, 5'd31, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd31, 5'd0}, {64'd0, 32'hFFFFFFFF, 32'd0}, 4'b0000);
    tbl_a[15] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd31, 5'd31}, {64'd0, 32'hFFFFFFFF, 32'hFFFFFFFF}, 4'b0000);

    tbl_b[0] = mk(2'b01, 5'd5, DB, 5'd0, 32'd0, 1'b0, 5'd0, {5'd7, 5'd0, 5'd5, 5'd5}, 128'd0, 4'b0000);
    tbl_b[1] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd7, 5'd5, 5'd0, 5'd5}, {32'd0, DB, 32'd0, DB}, 4'b0000);
    tbl_b[2] = mk(2'b01, 5'd0, 32'd1, 5'd0, 32'd0, 1'b0, 5'd0, {5'd0, 5'd0, 5'd5, 5'd0}, {32'd0, 32'd0, DB, 32'd0}, 4'b0000);
    tbl_b[3] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd5, 5'd0, 5'd0, 5'd0}, {DB, 96'd0}, 4'b0000);
    tbl_b[4] = mk(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, {5'd0, 5'd5, 5'd7, 5'd7}, {32'd0, DB, 32'd0, 32'd0}, 4'b0000);
    tbl_b[5] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd7, 5'd5, 5'd0, 5'd7}, {32'h22, DB, 32'd0, 32'h22}, 4'b0000);
    tbl_b[6] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, {4{5'd3}}, 128'd0, 4'b0000);
    tbl_b[7] = mk(2'b01, 5'd3, 32'h5, 5'd0, 32'd0, 1'b0, 5'd0, {5'd3, 5'd7, 5'd3, 5'd0}, {32'd0, 32'h22, 32'd0, 32'd0}, 4'b1010);
    tbl_b[8] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd3, 5'd7, 5'd3, 5'd0}, {32'h5, 32'h22, 32'h5, 32'd0}, 4'b0000);

    // Reset state, held and just after release.
    for (int c = 0; c < 5; c++) begin
      a_raddr = 10'($urandom);
      b_raddr = 20'($urandom);
      if (c == 4) rst_n = 1'b1;
      @(negedge clk);
      check("reset a_rdata", a_rdata[31:0] | a_rdata[63:32], 32'd0);
      check("reset b_rdata", b_rdata[31:0] | b_rdata[63:32] | b_rdata[95:64] | b_rdata[127:96], 32'd0);
      check("reset rbusy", {26'd0, b_rbusy, a_rbusy}, 32'd0);
      check("reset clr flags", {28'd0, a_clr_busy, a_clr_done, b_clr_busy, b_clr_done}, 32'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 16; i++) apply_vec(0, tbl_a[i], i);
    idle_inputs();
    for (int i = 0; i < 9; i++) apply_vec(1, tbl_b[i], i);
    idle_inputs();

    // Fill every entry and reserve it, then sweep.
    for (int i = 0; i < DEPTH; i++) begin
      drive_wr(0, 2'b01, 5'(i), 32'hA5000000 | i, 5'd0, 32'd0, 1'b1, 5'(i));
      @(posedge clk); #1;
    end
    idle_inputs();
    a_clr_req = 1'b1;
    @(posedge clk); #1;
    a_clr_req = 1'b0;
    count_clear(1, bc, dc);
    check("clear busy cycles", bc, 32);
    check("clear done pulses", dc, 1);
    for (int i = 0; i < DEPTH; i += 2) begin
      a_raddr = {5'(i + 1), 5'(i)};
      @(negedge clk);
      check($sformatf("after clear rdata x%0d", i), a_rdata[31:0], 32'd0);
      check($sformatf("after clear rdata x%0d", i + 1), a_rdata[63:32], 32'd0);
      check($sformatf("after clear rbusy x%0d", i), {30'd0, a_rbusy}, 32'd0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a sweep.
    drive_wr(0, 2'b11, 5'd20, 32'h1234, 5'd25, 32'h5678, 1'b1, 5'd25);
    @(posedge clk); #1;
    idle_inputs();
    a_raddr = {5'd25, 5'd20};
    @(negedge clk);
    check("pre-reset rdata x20", a_rdata[31:0], 32'h1234);
    check("pre-reset rbusy x25", 32'(a_rbusy[1]), 32'd1);
    @(posedge clk); #1;
    a_clr_req = 1'b1;
    @(posedge clk); #1;
    a_clr_req = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    check("cycle10 clr_busy", 32'(a_clr_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset clr_busy", 32'(a_clr_busy), 32'd0);
    check("async reset clr_done", 32'(a_clr_done), 32'd0);
    check("async reset rdata x20", a_rdata[31:0], 32'd0);
    check("async reset rdata x25", a_rdata[63:32], 32'd0);
    check("async reset rbusy", {30'd0, a_rbusy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_clr_req = 1'b1;
    @(posedge clk); #1;
    a_clr_req = 1'b0;
    count_clear(0, bc, dc);
    check("restart busy cycles", bc, 32);
    check("restart done pulses", dc, 1);

    // Random traffic on both instances against the reference model.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      logic [1:0]  r_we;
      logic [4:0]  r_wa0, r_wa1, r_rsa;
      logic [31:0] r_wd0, r_wd1;
      logic        r_rsv;
      r_we  = 2'($urandom);
      r_wa0 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      r_wa1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      r_rsa = 5'($urandom_range(0, 7));
      r_wd0 = $urandom;
      r_wd1 = $urandom;
      r_rsv = ($urandom_range(0, 3) == 0);
      drive_wr(0, r_we, r_wa0, r_wd0, r_wa1, r_wd1, r_rsv, r_rsa);
      drive_wr(1, r_we, r_wa0, r_wd0, r_wa1, r_wd1, r_rsv, r_rsa);
      for (int p = 0; p < 2; p++) a_raddr[p*5 +: 5] = 5'($urandom_range(0, 7));
      for (int p = 0; p < 4; p++) b_raddr[p*5 +: 5] = 5'($urandom_range(0, 7));
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        check($sformatf("rnd%0d A rdata%0d", c, p), a_rdata[p*32 +: 32], exp_rd(0, a_raddr[p*5 +: 5], 1));
        check($sformatf("rnd%0d A rbusy%0d", c, p), 32'(a_rbusy[p]), 32'(exp_rb(0, a_raddr[p*5 +: 5], 1)));
      end
      for (int p = 0; p < 4; p++) begin
        check($sformatf("rnd%0d B rdata%0d", c, p), b_rdata[p*32 +: 32], exp_rd(1, b_raddr[p*5 +: 5], 0));
        check($sformatf("rnd%0d B rbusy%0d", c, p), 32'(b_rbusy[p]), 32'(exp_rb(1, b_raddr[p*5 +: 5], 0)));
      end
      model_commit(0);
      model_commit(1);
      @(posedge clk); #1;
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
